regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Architectural register file plus per-register pending-write scoreboard, sitting
//  directly downstream of the writeback stage. Consumes its commit (wb_regno/wb_data/do_wb)
//  and serves decode: source operand reads with same-cycle bypass, and a stall when an
//  operand still has an in-flight producer.
// PARAMETERS
//  LEN_REGNO  5   register-number width; N_REG = 1<<LEN_REGNO registers
//  LEN_REG    32  register data width
//  LEN_PEND   2   per-register pending counter width; max in flight = 2**LEN_PEND-1
// PORTS
//  clk         in   1          clock, all state on posedge
//  rst         in   1          synchronous active-high reset
//  valid_i     in   1          decode presents an insn for issue
//  stall_o     out  1          issue blocked this cycle; decode must hold
//  rs1_regno   in   LEN_REGNO  source 1 register
//  rs1_used    in   1          insn reads rs1
//  rs2_regno   in   LEN_REGNO  source 2 register
//  rs2_used    in   1          insn reads rs2
//  rd_regno    in   LEN_REGNO  destination register
//  is_wb       in   1          insn will write rd
//  rs1_data    out  LEN_REG    operand 1 (combinational)
//  rs2_data    out  LEN_REG    operand 2 (combinational)
//  wb_valid    in   1          writeback stage holds valid insn (its valid_o)
//  do_wb       in   1          writeback requests register write
//  wb_regno    in   LEN_REGNO  write target
//  wb_data     in   LEN_REG    write data
//  err_o       out  1          sticky: commit seen on register with pend==0
// BEHAVIOUR
//  - commit = wb_valid & do_wb; issue = valid_i & ~stall_o & ~rst.
//  - Write: on commit, regs[wb_regno] <= wb_data at posedge.
//  - Read: rsN_data = (commit & wb_regno==rsN_regno) ? wb_data : regs[rsN_regno]
//    (same-cycle bypass; array itself updates one cycle later).
//  - pend[r]: +1 on issue with is_wb & rd==r; -1 on commit to r; both same cycle -> unchanged.
//  - hazN = rsN_used & pend[rsN]!=0 & ~(commit & wb_regno==rsN & pend[rsN]==1)
//    (last outstanding write landing now is bypassed, no stall).
//  - sat = is_wb & pend[rd_regno]==2**LEN_PEND-1 (counter full; stall, never wrap).
//  - stall_o = rst | (valid_i & (haz1 | haz2 | sat)); stall_o=0 when valid_i=0 and ~rst.
//  - Underflow: commit with pend[wb_regno]==0 -> counter stays 0, data still written,
//    err_o set and held until reset.
//  - Reset (synchronous, any time incl. mid-stream): next posedge all regs=0, all pend=0,
//    err_o=0; commits and issues in the reset cycle are discarded. While rst=1: stall_o=1,
//    rsN_data reflect array/bypass combinationally (don't-care), err_o holds until edge.
//  - No FSM beyond the counters; latency issue->stall visibility 1 cycle (pend registered).
// CONFIGURATION
//  R0_ZERO_EN defined: register 0 hardwired: rs*_data=0 for regno 0 (bypass too), commits
//   to 0 dropped, pend[0] never incremented, never stalls, no err_o from reg 0.
//  R0_ZERO_EN undefined: register 0 is an ordinary register.
// TESTING
//  1 reset, commit r3=0xDEADBEEF, next cycle read rs1=3 -> 0xDEADBEEF; same-cycle read also.
//  2 issue rd=5 is_wb; next insn rs1=5 -> stall_o=1 until commit r5=0x11 cycle, where
//    stall_o=0 and rs1_data=0x11 via bypass.
//  3 issue 3 writes to r7 (LEN_PEND=2), 4th issue to r7 -> stall_o=1; one commit -> clears.
//  4 commit r9 with pend[9]=0 -> err_o=1 stays set; rst pulse -> err_o=0, regs/pend cleared.
//  5 issue rd=4 and commit r4 same cycle with pend[4]=1 -> pend[4] remains 1.
//  6 R0_ZERO_EN: commit r0=0xFF, read rs1=0 -> 0, issue rd=0 then read r0 -> no stall.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Architectural register file with a per-register pending-write scoreboard.
//   It sits directly after writeback and serves decode. Commits from writeback
//   update the array. Decode reads its two source operands with a same-cycle
//   bypass of the committing value. Issue is stalled while a source register
//   still has an in-flight producer, or while the destination's pending
//   counter is full.
//
// Parameters
//   LEN_REGNO  register-number width (N_REG = 1 << LEN_REGNO)
//   LEN_REG    register data width
//   LEN_PEND   pending counter width (at most 2**LEN_PEND-1 writes in flight per reg)
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   valid_i / stall_o      decode handshake (stall_o is forced high during rst)
//   rs1_regno/rs1_used     source 1 select and use flag
//   rs2_regno/rs2_used     source 2 select and use flag
//   rd_regno/is_wb         destination select and write flag
//   rs1_data/rs2_data      combinational operands with writeback bypass
//   wb_valid/do_wb         writeback valid and write request (commit = both high)
//   wb_regno/wb_data       commit target and data
//   err_o                  sticky flag: commit seen on a register with no pending write
//
// Configuration
//   R0_ZERO_EN  when defined, register 0 is hardwired to zero. Commits to it are
//               dropped, and it never tracks pending writes or causes a stall.
module regfile_scoreboard #(
   parameter int LEN_REGNO = 5,
   parameter int LEN_REG   = 32,
   parameter int LEN_PEND  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_i,
   output logic                 stall_o,
   input  logic [LEN_REGNO-1:0] rs1_regno,
   input  logic                 rs1_used,
   input  logic [LEN_REGNO-1:0] rs2_regno,
   input  logic                 rs2_used,
   input  logic [LEN_REGNO-1:0] rd_regno,
   input  logic                 is_wb,
   output logic [LEN_REG-1:0]   rs1_data,
   output logic [LEN_REG-1:0]   rs2_data,
   input  logic                 wb_valid,
   input  logic                 do_wb,
   input  logic [LEN_REGNO-1:0] wb_regno,
   input  logic [LEN_REG-1:0]   wb_data,
   output logic                 err_o
);

   localparam int N_REG = 1 << LEN_REGNO;

   logic [LEN_REG-1:0]                regs [N_REG];
   logic [N_REG-1:0][LEN_PEND-1:0]    pend;
   logic [N_REG-1:0]                  inc_vec, dec_vec;

   logic commit, commit_eff, issue;
   logic haz1, haz2, sat, underflow;
   logic byp1, byp2;

   assign commit = wb_valid & do_wb;
`ifdef R0_ZERO_EN
   assign commit_eff = commit & (wb_regno != '0);
`else
   assign commit_eff = commit;
`endif

   // Operand read: the committing value is visible in the same cycle, because
   // the array only takes it at the next edge.
   assign byp1 = commit_eff & (wb_regno == rs1_regno);
   assign byp2 = commit_eff & (wb_regno == rs2_regno);

`ifdef R0_ZERO_EN
   assign rs1_data = (rs1_regno == '0) ? '0 : (byp1 ? wb_data : regs[rs1_regno]);
   assign rs2_data = (rs2_regno == '0) ? '0 : (byp2 ? wb_data : regs[rs2_regno]);
`else
   assign rs1_data = byp1 ? wb_data : regs[rs1_regno];
   assign rs2_data = byp2 ? wb_data : regs[rs2_regno];
`endif

   // A source is hazardous while it has pending writes. The exception is when
   // the last outstanding write is committing right now; the bypass covers it.
   assign haz1 = rs1_used & (pend[rs1_regno] != '0) &
                 ~(commit & (wb_regno == rs1_regno) & (pend[rs1_regno] == LEN_PEND'(1)));
   assign haz2 = rs2_used & (pend[rs2_regno] != '0) &
                 ~(commit & (wb_regno == rs2_regno) & (pend[rs2_regno] == LEN_PEND'(1)));
   // A full counter blocks another producer instead of letting it wrap.
   assign sat  = is_wb & (pend[rd_regno] == '1);

   assign stall_o   = rst | (valid_i & (haz1 | haz2 | sat));
   assign issue     = valid_i & ~stall_o & ~rst;
   assign underflow = commit_eff & (pend[wb_regno] == '0);

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      inc_vec[rd_regno] = issue & is_wb;
      // A commit with no pending write leaves the counter at zero and only flags err_o.
      dec_vec[wb_regno] = commit_eff & (pend[wb_regno] != '0);
`ifdef R0_ZERO_EN
      inc_vec[0] = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REG; i++) regs[i] <= '0;
         pend  <= '0;
         err_o <= 1'b0;
      end else begin
         if (commit_eff) regs[wb_regno] <= wb_data;
         for (int i = 0; i < N_REG; i++) begin
            // An increment and a decrement in the same cycle cancel out.
            if (inc_vec[i] & ~dec_vec[i])      pend[i] <= pend[i] + LEN_PEND'(1);
            else if (dec_vec[i] & ~inc_vec[i]) pend[i] <= pend[i] - LEN_PEND'(1);
         end
         if (underflow) err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_i = 1'b0;
   logic        stall_o;
   logic [4:0]  rs1_regno = '0, rs2_regno = '0, rd_regno = '0, wb_regno = '0;
   logic        rs1_used = 1'b0, rs2_used = 1'b0, is_wb = 1'b0;
   logic [31:0] rs1_data, rs2_data, wb_data = '0;
   logic        wb_valid = 1'b0, do_wb = 1'b0;
   logic        err_o;

   int n_pass = 0;
   int n_tot  = 0;

   regfile_scoreboard #(.LEN_REGNO(5), .LEN_REG(32), .LEN_PEND(2)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .stall_o(stall_o),
      .rs1_regno(rs1_regno), .rs1_used(rs1_used),
      .rs2_regno(rs2_regno), .rs2_used(rs2_used),
      .rd_regno(rd_regno), .is_wb(is_wb),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_valid(wb_valid), .do_wb(do_wb), .wb_regno(wb_regno), .wb_data(wb_data),
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   // One record per cycle: inputs, then expected outputs, then check enables.
   typedef struct {
      int rst, vld, rs1, u1, rs2, u2, rd, wb, wbv, dwb, wreg, wdata;
      int e_stall, e_rs1, e_rs2, e_err, chk_d, chk_e;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s vec%0d: got %h want %h", name, idx, act, exp);
   endtask

   // Inputs are driven after the falling edge and outputs sampled 1 ns later,
   // well before the next rising edge.
   task automatic apply(input int idx, input vec_t t);
      @(negedge clk);
      rst = t.rst[0];        valid_i = t.vld[0];
      rs1_regno = 5'(t.rs1); rs1_used = t.u1[0];
      rs2_regno = 5'(t.rs2); rs2_used = t.u2[0];
      rd_regno = 5'(t.rd);   is_wb = t.wb[0];
      wb_valid = t.wbv[0];   do_wb = t.dwb[0];
      wb_regno = 5'(t.wreg); wb_data = 32'(t.wdata);
      #1;
      chk("stall", idx, 32'(stall_o), 32'(t.e_stall));
      if (t.chk_d != 0) begin
         chk("rs1_data", idx, rs1_data, 32'(t.e_rs1));
         chk("rs2_data", idx, rs2_data, 32'(t.e_rs2));
      end
      if (t.chk_e != 0) chk("err", idx, 32'(err_o), 32'(t.e_err));
   endtask

   initial begin
      //                 rst vld rs1 u1 rs2 u2 rd wb wbv dwb wreg wdata         stall rs1          rs2          err  cd ce
      // reset, then a plain commit and read of r3
      tbl.push_back(vec_t'{1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,              1, 0,           0,           0,   0, 0});
      tbl.push_back(vec_t'{0, 0,  3, 0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  3, 0, 0, 0, 3, 1, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 0,  3, 1, 0, 0, 0, 0, 1, 1, 3, 32'hDEADBEEF,   0, 32'hDEADBEEF, 0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 0,  3, 0, 3, 0, 0, 0, 0, 0, 0, 0,              0, 32'hDEADBEEF, 32'hDEADBEEF, 0,  1, 1});
      // RAW on r5: stall until the landing commit, which bypasses
      tbl.push_back(vec_t'{0, 1,  0, 0, 0, 0, 5, 1, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  5, 1, 0, 0, 6, 0, 0, 0, 0, 0,              1, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  5, 1, 0, 0, 6, 0, 0, 0, 0, 0,              1, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  5, 1, 0, 0, 6, 0, 1, 1, 5, 32'h11,         0, 32'h11,      0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 32'h11,      0,           0,   1, 1});
      // fill r7 counter to 3, 4th producer stalls, a commit frees one slot
      tbl.push_back(vec_t'{0, 1,  7, 0, 0, 0, 7, 1, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  7, 0, 0, 0, 7, 1, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  7, 0, 0, 0, 7, 1, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  7, 0, 0, 0, 7, 1, 0, 0, 0, 0,              1, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  7, 0, 0, 0, 7, 1, 1, 1, 7, 32'h77,         1, 32'h77,      0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  7, 0, 0, 0, 7, 1, 0, 0, 0, 0,              0, 32'h77,      0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 0,  0, 0, 7, 1, 0, 0, 1, 1, 7, 32'h70,         0, 0,           32'h70,      0,   1, 1});
      tbl.push_back(vec_t'{0, 0,  0, 0, 7, 1, 0, 0, 1, 1, 7, 32'h71,         0, 0,           32'h71,      0,   1, 1});
      tbl.push_back(vec_t'{0, 0,  0, 0, 7, 1, 0, 0, 1, 1, 7, 32'h72,         0, 0,           32'h72,      0,   1, 1});
      // issue+commit on r4 in one cycle keeps pend[4] at 1
      tbl.push_back(vec_t'{0, 1,  0, 0, 0, 0, 4, 1, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  4, 0, 0, 0, 4, 1, 1, 1, 4, 32'h44,         0, 32'h44,      0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  4, 1, 0, 0, 0, 0, 0, 0, 0, 0,              1, 32'h44,      0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  4, 1, 0, 0, 0, 0, 1, 1, 4, 32'h45,         0, 32'h45,      0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  4, 1, 0, 0, 0, 0, 0, 0, 0, 0,              0, 32'h45,      0,           0,   1, 1});
      // underflow on r9: data written, err sticky; r10 left pending; mid-stream reset clears all
      tbl.push_back(vec_t'{0, 0,  0, 0, 9, 0, 0, 0, 1, 1, 9, 32'h99,         0, 0,           32'h99,      0,   1, 1});
      tbl.push_back(vec_t'{0, 0,  0, 0, 9, 0, 0, 0, 0, 0, 0, 0,              0, 0,           32'h99,      1,   1, 1});
      tbl.push_back(vec_t'{0, 1,  0, 0, 9, 0,10, 1, 0, 0, 0, 0,              0, 0,           32'h99,      1,   1, 1});
      tbl.push_back(vec_t'{1, 1,  0, 0, 0, 0, 9, 1, 1, 1, 3, 32'h5,          1, 0,           0,           1,   0, 1});
      tbl.push_back(vec_t'{0, 0,  3, 0, 9, 0, 0, 0, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1, 10, 1, 9, 1, 0, 0, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  9, 1, 3, 1, 0, 0, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});

      // register 0 corner sequence
`ifdef R0_ZERO_EN
      tbl.push_back(vec_t'{0, 0,  0, 1, 0, 0, 0, 0, 1, 1, 0, 32'hFF,         0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  0, 1, 0, 1, 0, 0, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
`else
      tbl.push_back(vec_t'{0, 1,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0,              0, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0,              1, 0,           0,           0,   1, 1});
      tbl.push_back(vec_t'{0, 1,  0, 1, 0, 0, 0, 0, 1, 1, 0, 32'hFF,         0, 32'hFF,      32'hFF,      0,   1, 1});
      tbl.push_back(vec_t'{0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,              0, 32'hFF,      32'hFF,      0,   1, 1});
`endif

      foreach (tbl[i]) apply(i, tbl[i]);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   // Overall time bound so the run always ends even if the stimulus loop stalls.
   initial begin
      #100000;
      $display("FAIL timeout: bench still running at %0t, want finish earlier", $time);
      $display("%0d/%0d checks passed", n_pass, n_tot + 1);
      $finish;
   end

endmodule
